// File: rtl/adxl362_pkg.sv
// ADXL362 register-interface emulation: shared constants.
// Commands, register addresses and responder FSM encoding.
package adxl362_pkg;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_REVID     = 6'h03;
  localparam logic [5:0] ADDR_XDATA8    = 6'h08;
  localparam logic [5:0] ADDR_YDATA8    = 6'h09;
  localparam logic [5:0] ADDR_STATUS    = 6'h0B;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_FILTER_CTL = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;

  localparam logic [7:0] REVID_VAL      = 8'h02;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/adxl362_spi_slave_sync.sv
// SPI pin synchronizer and edge detector.
// Edges compare the last sync stage with one extra flop.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_high,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // Shift pins through the sync chains; idle values on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q        <= {cs_q[SYNC_STAGES-2:0], cs};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
  assign cs_fall   = ~cs_q[SYNC_STAGES-1] & cs_prev_q;
  assign cs_high   = cs_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/adxl362_spi_slave.sv
// ADXL362-compatible SPI mode-0 responder.
// Serves an auto-incrementing register map with coherent X/Y bursts.
module adxl362_spi_slave
  import adxl362_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic        cmd_err
);

  logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (iclk),
    .rst_n    (irst_n),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_fall  (cs_fall),
    .cs_high  (cs_high),
    .mosi_s   (mosi_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  byte_q, byte_d;
  logic [5:0]  addr_q, addr_d;
  logic        is_wr_q, is_wr_d;
  logic        rd_first_q, rd_first_d;
  logic [2:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  power_q, power_d;
  logic [7:0]  filter_q, filter_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic        cmd_err_q, cmd_err_d;
  logic [15:0] shx_q, shx_d;
  logic [15:0] shy_q, shy_d;
  logic [15:0] snx_q, snx_d;
  logic [15:0] sny_q, sny_d;
  logic        upd_q, upd_d;

  logic [7:0]  in_byte;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_data;

  assign in_byte = {byte_q, mosi_s};
  assign rd_addr = rd_first_q ? addr_q : addr_q + 6'd1;

  // Register map read mux for the byte about to be shifted out.
  always_comb begin
    rd_data = 8'h00;
    unique case (rd_addr)
      ADDR_DEVID_AD:   rd_data = DEVID_AD;
      ADDR_DEVID_MST:  rd_data = DEVID_MST;
      ADDR_PARTID:     rd_data = PARTID;
      ADDR_REVID:      rd_data = REVID_VAL;
      ADDR_XDATA8:     rd_data = snx_q[11:4];
      ADDR_YDATA8:     rd_data = sny_q[11:4];
      ADDR_STATUS:     rd_data = {7'd0, upd_q};
      ADDR_XDATA_L:    rd_data = snx_q[7:0];
      ADDR_XDATA_H:    rd_data = snx_q[15:8];
      ADDR_YDATA_L:    rd_data = sny_q[7:0];
      ADDR_YDATA_H:    rd_data = sny_q[15:8];
      ADDR_ZDATA_L:    rd_data = 8'h00;
      ADDR_ZDATA_H:    rd_data = 8'h00;
      ADDR_FILTER_CTL: rd_data = filter_q;
      ADDR_POWER_CTL:  rd_data = power_q;
      default:         rd_data = 8'h00;
    endcase
  end

  // Next-state logic for the transaction FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    rd_first_d  = rd_first_q;
    out_cnt_d   = out_cnt_q;
    shift_d     = shift_q;
    power_d     = power_q;
    filter_d    = filter_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    cmd_err_d   = 1'b0;
    shx_d       = shx_q;
    shy_d       = shy_q;
    snx_d       = snx_q;
    sny_d       = sny_q;
    upd_d       = upd_q;

    if (sample_valid) begin
      shx_d = x_in;
      shy_d = y_in;
      upd_d = 1'b1;
    end

    if (cs_high) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            snx_d     = sample_valid ? x_in : shx_q;
            sny_d     = sample_valid ? y_in : shy_q;
            upd_d     = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            byte_d    = in_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (in_byte == CMD_READ) begin
                state_d = ST_ADDR;
                is_wr_d = 1'b0;
              end else if (in_byte == CMD_WRITE) begin
                state_d = ST_ADDR;
                is_wr_d = 1'b1;
              end else begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            byte_d    = in_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              addr_d     = in_byte[5:0];
              shift_d    = 8'h00;
              rd_first_d = 1'b1;
              out_cnt_d  = 3'd0;
              state_d    = is_wr_q ? ST_WR_DATA : ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (sclk_fall) begin
            if (rd_first_q) begin
              shift_d    = rd_data;
              rd_first_d = 1'b0;
              out_cnt_d  = 3'd0;
            end else if (out_cnt_q == 3'd7) begin
              addr_d    = addr_q + 6'd1;
              shift_d   = rd_data;
              out_cnt_d = 3'd0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              out_cnt_d = out_cnt_q + 3'd1;
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise) begin
            byte_d    = in_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_q == ADDR_FILTER_CTL) filter_d = in_byte;
              if (addr_q == ADDR_POWER_CTL)  power_d  = in_byte;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              addr_d      = addr_q + 6'd1;
            end
          end
        end
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_q      <= 7'd0;
      addr_q      <= 6'd0;
      is_wr_q     <= 1'b0;
      rd_first_q  <= 1'b0;
      out_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      power_q     <= POWER_CTL_RST;
      filter_q    <= FILTER_CTL_RST;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      cmd_err_q   <= 1'b0;
      shx_q       <= 16'h0000;
      shy_q       <= 16'h0000;
      snx_q       <= 16'h0000;
      sny_q       <= 16'h0000;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      rd_first_q  <= rd_first_d;
      out_cnt_q   <= out_cnt_d;
      shift_q     <= shift_d;
      power_q     <= power_d;
      filter_q    <= filter_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      cmd_err_q   <= cmd_err_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
      snx_q       <= snx_d;
      sny_q       <= sny_d;
      upd_q       <= upd_d;
    end
  end

  assign miso       = (state_q == ST_RD_DATA) && !cs_high && shift_q[7];
  assign power_ctl  = power_q;
  assign filter_ctl = filter_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Directed bench for the ADXL362 SPI responder.
// SCLK runs at 1/16 of iclk; stimulus changes on iclk falling edges.
module tb_adxl362_spi_slave;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        sclk, cs, mosi;
  logic        miso;
  logic [15:0] x_in, y_in;
  logic        sample_valid;
  logic [7:0]  power_ctl, filter_ctl;
  logic        wr_strobe;
  logic [5:0]  wr_addr;
  logic        cmd_err;

  int tests = 0;
  int fails = 0;

  int ws_cnt = 0;
  int ce_cnt = 0;
  int mh_cnt = 0;
  logic [5:0] wa [0:15];

  logic [7:0] rx;
  logic [7:0] rxb [0:7];
  int ws0, ce0, mh0;

  always #5 iclk = ~iclk;

  adxl362_spi_slave dut (
    .iclk        (iclk),
    .irst_n      (irst_n),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .x_in        (x_in),
    .y_in        (y_in),
    .sample_valid(sample_valid),
    .power_ctl   (power_ctl),
    .filter_ctl  (filter_ctl),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .cmd_err     (cmd_err)
  );

  always @(posedge iclk) begin
    if (irst_n) begin
      if (wr_strobe) begin
        wa[ws_cnt % 16] <= wr_addr;
        ws_cnt <= ws_cnt + 1;
      end
      if (cmd_err) ce_cnt <= ce_cnt + 1;
      if (miso) mh_cnt <= mh_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n,
                          output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #80;
      r = {r[6:0], miso};
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic begin_tx;
    cs = 1'b0;
    #100;
  endtask

  task automatic end_tx;
    #80;
    cs = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  task automatic read_regs(input logic [7:0] a, input int n);
    logic [7:0] d;
    begin_tx();
    spi_byte(8'h0B, d);
    spi_byte(a, d);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, d);
      rxb[i] = d;
    end
    end_tx();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] v);
    logic [7:0] d;
    begin_tx();
    spi_byte(8'h0A, d);
    spi_byte(a, d);
    spi_byte(v, d);
    end_tx();
  endtask

  task automatic pulse_sv(input logic [15:0] x, input logic [15:0] y);
    x_in = x;
    y_in = y;
    sample_valid = 1'b1;
    #10;
    sample_valid = 1'b0;
  endtask

  initial begin
    irst_n = 1'b0;
    sclk = 1'b0;
    cs = 1'b1;
    mosi = 1'b0;
    x_in = 16'h0;
    y_in = 16'h0;
    sample_valid = 1'b0;
    #20;
    chk("rst_miso", {15'd0, miso}, 16'h0);
    chk("rst_power", {8'd0, power_ctl}, 16'h00);
    chk("rst_filter", {8'd0, filter_ctl}, 16'h13);
    chk("rst_wrstb", {15'd0, wr_strobe}, 16'h0);
    chk("rst_wraddr", {10'd0, wr_addr}, 16'h0);
    chk("rst_cmderr", {15'd0, cmd_err}, 16'h0);
    irst_n = 1'b1;
    #40;

    ce0 = ce_cnt;
    read_regs(8'h00, 4);
    chk("id_ad", {8'd0, rxb[0]}, 16'hAD);
    chk("id_1d", {8'd0, rxb[1]}, 16'h1D);
    chk("id_f2", {8'd0, rxb[2]}, 16'hF2);
    chk("id_rev", {8'd0, rxb[3]}, 16'h02);
    chk("id_cmderr", 16'(ce_cnt - ce0), 16'd0);

    pulse_sv(16'hBEEF, 16'h1234);
    #40;
    begin_tx();
    spi_byte(8'h0B, rx);
    spi_byte(8'h0E, rx);
    spi_byte(8'h00, rx);
    rxb[0] = rx;
    spi_byte(8'h00, rx);
    rxb[1] = rx;
    pulse_sv(16'h0000, 16'h1234);
    #70;
    spi_byte(8'h00, rx);
    rxb[2] = rx;
    spi_byte(8'h00, rx);
    rxb[3] = rx;
    end_tx();
    chk("snap_xl", {8'd0, rxb[0]}, 16'hEF);
    chk("snap_xh", {8'd0, rxb[1]}, 16'hBE);
    chk("snap_yl", {8'd0, rxb[2]}, 16'h34);
    chk("snap_yh", {8'd0, rxb[3]}, 16'h12);

    read_regs(8'h0E, 2);
    chk("snap2_xl", {8'd0, rxb[0]}, 16'h00);
    chk("snap2_xh", {8'd0, rxb[1]}, 16'h00);

    ws0 = ws_cnt;
    write_reg(8'h2D, 8'h02);
    write_reg(8'h2C, 8'h55);
    chk("wr_power", {8'd0, power_ctl}, 16'h02);
    chk("wr_filter", {8'd0, filter_ctl}, 16'h55);
    chk("wr_nstb", 16'(ws_cnt - ws0), 16'd2);
    chk("wr_addr0", {10'd0, wa[ws0 % 16]}, 16'h2D);
    chk("wr_addr1", {10'd0, wa[(ws0 + 1) % 16]}, 16'h2C);
    read_regs(8'h2C, 2);
    chk("rb_filter", {8'd0, rxb[0]}, 16'h55);
    chk("rb_power", {8'd0, rxb[1]}, 16'h02);

    ce0 = ce_cnt;
    mh0 = mh_cnt;
    begin_tx();
    spi_byte(8'h0F, rx);
    spi_byte(8'hFF, rx);
    rxb[0] = rx;
    spi_byte(8'h00, rx);
    rxb[1] = rx;
    end_tx();
    chk("bad_cmderr", 16'(ce_cnt - ce0), 16'd1);
    chk("bad_misohi", 16'(mh_cnt - mh0), 16'd0);
    chk("bad_rx0", {8'd0, rxb[0]}, 16'h00);
    chk("bad_rx1", {8'd0, rxb[1]}, 16'h00);
    read_regs(8'h00, 1);
    chk("after_bad", {8'd0, rxb[0]}, 16'hAD);

    read_regs(8'h3F, 2);
    chk("wrap_3f", {8'd0, rxb[0]}, 16'h00);
    chk("wrap_00", {8'd0, rxb[1]}, 16'hAD);

    ws0 = ws_cnt;
    begin_tx();
    spi_byte(8'h0A, rx);
    spi_byte(8'h2D, rx);
    spi_bits(8'hFF, 4, rx);
    end_tx();
    chk("part_power", {8'd0, power_ctl}, 16'h02);
    chk("part_nstb", 16'(ws_cnt - ws0), 16'd0);

    begin_tx();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    #80;
    chk("mid_pre", {15'd0, miso}, 16'h1);
    irst_n = 1'b0;
    #1;
    chk("mid_miso", {15'd0, miso}, 16'h0);
    chk("mid_power", {8'd0, power_ctl}, 16'h00);
    chk("mid_filter", {8'd0, filter_ctl}, 16'h13);
    chk("mid_wrstb", {15'd0, wr_strobe}, 16'h0);
    chk("mid_wraddr", {10'd0, wr_addr}, 16'h0);
    chk("mid_cmderr", {15'd0, cmd_err}, 16'h0);
    #9;
    cs = 1'b1;
    #100;
    irst_n = 1'b1;
    #100;
    read_regs(8'h00, 1);
    chk("post_rst", {8'd0, rxb[0]}, 16'hAD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
